// File: rtl/data_memory_responder.sv
// Responder end of the EX/MEM memory interface: single-port word array with a fixed,
// configurable access latency; stalls the pipeline until the presented access completes.
module data_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 32,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o
);

    localparam int unsigned IdxW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LatM1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic            is_wr_q;
    logic [IdxW-1:0] idx_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            req;
    logic [IdxW-1:0] idx;
    logic            commit;
    logic            unused_addr;

    assign req     = MemRead_i | MemWrite_i;
    assign idx     = addr_i[IdxW+1:2];
    assign stall_o = req & (state_q != StDone);
    assign data_o  = rdata_q;
    // A write lands on the edge leaving DONE unless that edge is a reset.
    assign commit  = rst_i & (state_q == StDone) & is_wr_q;

    // Byte offset and bits above the array span are ignored by design.
    assign unused_addr = ^{addr_i[31:IdxW+2], addr_i[1:0]};

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            is_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req) begin
                        is_wr_q <= MemWrite_i;
                        idx_q   <= idx;
                        wdata_q <= data_i;
                        cnt_q   <= LatM1;
                        if (LATENCY == 1) begin
                            state_q <= StDone;
                            if (!MemWrite_i) begin
                                rdata_q <= mem_q[idx];
                            end
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (!req) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= StDone;
                            if (!is_wr_q) begin
                                rdata_q <= mem_q[idx_q];
                            end
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk_i) begin
        if (commit) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench: three responders (latency 2, 1, 4) driven with directed and random
// accesses, checked cycle by cycle against an array-based reference model.
module tb_data_memory_responder;

    localparam int          N     = 3;
    localparam int unsigned DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst   [N];
    logic        rd    [N];
    logic        wr    [N];
    logic [31:0] addr  [N];
    logic [31:0] din   [N];
    logic [31:0] dout  [N];
    logic        stall [N];

    logic [31:0] model   [N][DEPTH];
    logic [31:0] exp_out [N];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH_WORDS(32), .LATENCY(2)) u_dut_l2 (
        .clk_i(clk), .rst_i(rst[0]), .MemRead_i(rd[0]), .MemWrite_i(wr[0]),
        .addr_i(addr[0]), .data_i(din[0]), .data_o(dout[0]), .stall_o(stall[0])
    );
    data_memory_responder #(.DEPTH_WORDS(32), .LATENCY(1)) u_dut_l1 (
        .clk_i(clk), .rst_i(rst[1]), .MemRead_i(rd[1]), .MemWrite_i(wr[1]),
        .addr_i(addr[1]), .data_i(din[1]), .data_o(dout[1]), .stall_o(stall[1])
    );
    data_memory_responder #(.DEPTH_WORDS(32), .LATENCY(4)) u_dut_l4 (
        .clk_i(clk), .rst_i(rst[2]), .MemRead_i(rd[2]), .MemWrite_i(wr[2]),
        .addr_i(addr[2]), .data_i(din[2]), .data_o(dout[2]), .stall_o(stall[2])
    );

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    // Called just after a rising edge. Presents one request until it completes, then
    // replaces addr/data with (sa, sd) for the rest of the access to prove they are latched.
    task automatic access(input int d, input bit do_rd, input bit do_wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] sa, input logic [31:0] sd);
        int l;
        int w;
        l = lat_of(d);
        w = word_of(a);
        rd[d] = do_rd; wr[d] = do_wr; addr[d] = a; din[d] = wd;
        for (int k = 0; k <= l; k++) begin
            @(negedge clk);
            if (k == l && !do_wr) exp_out[d] = model[d][w];
            checks++;
            if (stall[d] !== 1'(k < l)) begin
                errors++;
                $display("FAIL access_stall d=%0d a=%h k=%0d got=%b want=%b",
                         d, a, k, stall[d], 1'(k < l));
            end
            checks++;
            if (dout[d] !== exp_out[d]) begin
                errors++;
                $display("FAIL access_data d=%0d a=%h k=%0d got=%h want=%h",
                         d, a, k, dout[d], exp_out[d]);
            end
            @(posedge clk); #1;
            addr[d] = sa; din[d] = sd;
        end
        if (do_wr) model[d][w] = wd;
        rd[d] = 1'b0; wr[d] = 1'b0;
    endtask

    task automatic idle(input int d, input int n);
        for (int k = 0; k < n; k++) begin
            addr[d] = $urandom(); din[d] = $urandom();
            @(negedge clk);
            checks++;
            if (stall[d] !== 1'b0 || dout[d] !== exp_out[d]) begin
                errors++;
                $display("FAIL idle d=%0d got stall=%b data=%h want stall=0 data=%h",
                         d, stall[d], dout[d], exp_out[d]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < N; d++) begin
            rst[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; din[d] = '0;
            exp_out[d] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) rst[d] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            checks++;
            if (dout[d] !== 32'd0 || stall[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset d=%0d got data=%h stall=%b want data=0 stall=0",
                         d, dout[d], stall[d]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        for (int d = 0; d < N; d++)
            for (int w = 0; w < int'(DEPTH); w++)
                access(d, 1'b0, 1'b1, 32'(w * 4) | ($urandom() & 32'h3), $urandom(),
                       $urandom(), $urandom());
    endtask

    task automatic test_write_read_lat2();
        access(0, 1'b0, 1'b1, 32'h8, 32'hDEADBEEF, $urandom(), $urandom());
        idle(0, 1);
        access(0, 1'b1, 1'b0, 32'h8, $urandom(), $urandom(), $urandom());
    endtask

    task automatic test_back_to_back_lat1();
        access(1, 1'b0, 1'b1, 32'h0, 32'h11, $urandom(), $urandom());
        access(1, 1'b1, 1'b0, 32'h0, $urandom(), $urandom(), $urandom());
        access(0, 1'b0, 1'b1, 32'h24, $urandom(), $urandom(), $urandom());
        access(0, 1'b1, 1'b0, 32'h24, $urandom(), $urandom(), $urandom());
    endtask

    task automatic test_latched_inputs();
        access(0, 1'b0, 1'b1, 32'hC, 32'h33, 32'h4, 32'h55);
        access(0, 1'b1, 1'b0, 32'hC, $urandom(), $urandom(), $urandom());
        access(0, 1'b1, 1'b0, 32'h4, $urandom(), $urandom(), $urandom());
    endtask

    task automatic test_alias();
        access(0, 1'b0, 1'b1, 32'h83, 32'hA5A5A5A5, $urandom(), $urandom());
        access(0, 1'b1, 1'b0, 32'h0, $urandom(), $urandom(), $urandom());
        access(0, 1'b1, 1'b0, 32'hFFFF_FF02, $urandom(), $urandom(), $urandom());
    endtask

    task automatic test_both_high();
        access(0, 1'b1, 1'b0, 32'h20, $urandom(), $urandom(), $urandom());
        access(0, 1'b1, 1'b1, 32'h10, 32'h77, $urandom(), $urandom());
        access(0, 1'b1, 1'b0, 32'h10, $urandom(), $urandom(), $urandom());
    endtask

    task automatic test_abort_reset();
        wr[0] = 1'b1; rd[0] = 1'b0; addr[0] = 32'h14; din[0] = 32'h99;
        @(negedge clk);
        checks++;
        if (stall[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_reset_req got stall=%b want 1", stall[0]);
        end
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b1; wr[0] = 1'b0;
        exp_out[0] = 32'd0;
        @(negedge clk);
        checks++;
        if (stall[0] !== 1'b0 || dout[0] !== 32'd0) begin
            errors++;
            $display("FAIL abort_reset_state got stall=%b data=%h want stall=0 data=0",
                     stall[0], dout[0]);
        end
        @(posedge clk); #1;
        idle(0, 2);
        access(0, 1'b1, 1'b0, 32'h14, $urandom(), $urandom(), $urandom());
    endtask

    task automatic test_abort_drop(input int d);
        wr[d] = 1'b1; rd[d] = 1'b0; addr[d] = 32'h14; din[d] = 32'h99;
        @(negedge clk);
        checks++;
        if (stall[d] !== 1'b1) begin
            errors++;
            $display("FAIL abort_drop_req d=%0d got stall=%b want 1", d, stall[d]);
        end
        @(posedge clk); #1;
        wr[d] = 1'b0;
        idle(d, 2);
        access(d, 1'b1, 1'b0, 32'h14, $urandom(), $urandom(), $urandom());
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            int d;
            int op;
            d  = int'($urandom_range(0, N - 1));
            op = int'($urandom_range(0, 3));
            access(d, op != 1, op != 0, $urandom(), $urandom(), $urandom(), $urandom());
            if ($urandom_range(0, 3) == 0) idle(d, int'($urandom_range(1, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read_lat2();
        test_back_to_back_lat1();
        test_latched_inputs();
        test_alias();
        test_both_high();
        test_abort_reset();
        test_abort_drop(0);
        test_abort_drop(2);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
